// File: rtl/stack_cache_line_fetch_unit.sv
// Line-fetch engine for the stack cache. Fetch commands are queued, each one
// waits until its destination slot is clean, then a single line read is issued
// and the returned beats are streamed into line storage. A done pulse marks the
// slot ready. Cancel flushes queued work and squashes any read already in flight.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | nothing in progress; pop the next command if one is queued
// WAIT_CLEAN | holding the current command until its slot has no dirty data
// REQ        | line read offered to memory, waiting for acceptance
// BEAT       | collecting response beats (fills suppressed when squashed)
// DONE       | final beat written this cycle; done pulse asserted
module stack_cache_line_fetch_unit #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int LINE_BEATS  = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          sync_rst,
  input  logic                          clk_en,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [1:0]                    cmd_slot,
  input  logic                          cancel,
  input  logic [3:0]                    slot_clean,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  input  logic                          mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]         mem_resp_data,
  output logic                          fill_we,
  output logic [1:0]                    fill_slot,
  output logic [$clog2(LINE_BEATS)-1:0] fill_beat,
  output logic [DATA_WIDTH-1:0]         fill_data,
  output logic                          done_valid,
  output logic [1:0]                    done_slot,
  output logic                          busy
);

  localparam int BEAT_W = $clog2(LINE_BEATS);
  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int OFS_W  = $clog2(LINE_BEATS * DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'((1 << OFS_W) - 1));
  localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(LINE_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CLEAN,
    S_REQ,
    S_BEAT,
    S_DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [1:0]              cur_slot;
  logic [BEAT_W-1:0]       beat_cnt;
  logic                    squash;

  logic [ADDR_WIDTH-1:0]   q_addr [QUEUE_DEPTH];
  logic [1:0]              q_slot [QUEUE_DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [CNT_W-1:0]        count;

  logic                    full;
  logic                    push;
  logic                    pop;
  logic [PTR_W-1:0]        wr_idx;

  assign full      = (count == CNT_W'(QUEUE_DEPTH));
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  // A cancelled unit does not start the next command in the same cycle.
  assign pop       = (state == S_IDLE) && (count != '0) && !cancel;
  // A command arriving together with cancel becomes the only entry, at slot 0.
  assign wr_idx    = cancel ? '0 : wr_ptr;

  assign mem_req_addr = cur_addr;
  assign busy         = (state != S_IDLE) || (count != '0);

  // Command storage; entries are only read when the count says they are valid.
  always_ff @(posedge clk) begin
    if (clk_en && push) begin
      q_addr[wr_idx] <= cmd_addr & ALIGN_MASK;
      q_slot[wr_idx] <= cmd_slot;
    end
  end

  // Queue pointers and occupancy, with cancel flushing everything but a same-cycle push.
  always_ff @(posedge clk or posedge sync_rst) begin
    if (sync_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clk_en) begin
      if (cancel) begin
        rd_ptr <= '0;
        wr_ptr <= push ? PTR_W'(1) : '0;
        count  <= push ? CNT_W'(1) : '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Fetch sequencer with registered request, fill and done outputs.
  always_ff @(posedge clk or posedge sync_rst) begin
    if (sync_rst) begin
      state         <= S_IDLE;
      cur_addr      <= '0;
      cur_slot      <= '0;
      beat_cnt      <= '0;
      squash        <= 1'b0;
      mem_req_valid <= 1'b0;
      fill_we       <= 1'b0;
      fill_slot     <= '0;
      fill_beat     <= '0;
      fill_data     <= '0;
      done_valid    <= 1'b0;
      done_slot     <= '0;
    end else if (clk_en) begin
      fill_we    <= 1'b0;
      done_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          squash <= 1'b0;
          if (pop) begin
            cur_addr <= q_addr[rd_ptr];
            cur_slot <= q_slot[rd_ptr];
            state    <= S_WAIT_CLEAN;
          end
        end
        S_WAIT_CLEAN: begin
          if (cancel) begin
            state <= S_IDLE;
          end else if (slot_clean[cur_slot]) begin
            mem_req_valid <= 1'b1;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          // Once memory takes the request the beats will arrive regardless,
          // so a simultaneous cancel only squashes the fill.
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            beat_cnt      <= '0;
            squash        <= cancel;
            state         <= S_BEAT;
          end else if (cancel) begin
            mem_req_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end
        S_BEAT: begin
          if (cancel) squash <= 1'b1;
          if (mem_resp_valid) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (!squash && !cancel) begin
              fill_we   <= 1'b1;
              fill_slot <= cur_slot;
              fill_beat <= beat_cnt;
              fill_data <= mem_resp_data;
            end
            if (beat_cnt == LAST_BEAT) begin
              if (squash || cancel) begin
                state <= S_IDLE;
              end else begin
                done_valid <= 1'b1;
                done_slot  <= cur_slot;
                state      <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_cache_line_fetch_unit.sv
// Directed bench for the stack-cache line fetch unit. Stimulus pushes expected
// requests, fills and done pulses into queues; a negedge monitor checks them.
module tb_stack_cache_line_fetch_unit;

  logic        clk;
  logic        sync_rst;
  logic        clk_en;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic [1:0]  cmd_slot;
  logic        cancel;
  logic [3:0]  slot_clean;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [15:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [15:0] mem_resp_data;
  logic        fill_we;
  logic [1:0]  fill_slot;
  logic [1:0]  fill_beat;
  logic [15:0] fill_data;
  logic        done_valid;
  logic [1:0]  done_slot;
  logic        busy;

  stack_cache_line_fetch_unit dut (
    .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_slot(cmd_slot),
    .cancel(cancel), .slot_clean(slot_clean),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .fill_we(fill_we), .fill_slot(fill_slot), .fill_beat(fill_beat), .fill_data(fill_data),
    .done_valid(done_valid), .done_slot(done_slot), .busy(busy)
  );

  typedef struct packed {
    logic [1:0]  slot;
    logic [1:0]  beat;
    logic [15:0] data;
  } fill_t;

  logic [15:0] exp_req[$];
  fill_t       exp_fill[$];
  logic [1:0]  exp_done[$];

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_req_addr"}, mem_req_addr, 0);
    chk({tag, "_fill_we"}, fill_we, 0);
    chk({tag, "_fill_slot"}, fill_slot, 0);
    chk({tag, "_fill_beat"}, fill_beat, 0);
    chk({tag, "_fill_data"}, fill_data, 0);
    chk({tag, "_done_valid"}, done_valid, 0);
    chk({tag, "_done_slot"}, done_slot, 0);
  endtask

  task automatic push_cmd(input logic [15:0] addr, input logic [1:0] slot, input logic [15:0] exp_addr,
                          input bit expect_req);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_slot  = slot;
    if (expect_req) exp_req.push_back(exp_addr);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    int k = 0;
    while (!mem_req_valid && k < budget) begin
      tick();
      k++;
    end
    if (!mem_req_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL req_timeout got=mem_req_valid_low expected=request_within_%0d_cycles", budget);
    end
  endtask

  task automatic accept();
    wait_req(40);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
  endtask

  task automatic beat(input logic [1:0] s, input int i, input logic [15:0] d, input bit expect_it);
    fill_t f;
    mem_resp_valid = 1'b1;
    mem_resp_data  = d;
    if (expect_it) begin
      f.slot = s;
      f.beat = 2'(i);
      f.data = d;
      exp_fill.push_back(f);
      if (i == 3) exp_done.push_back(s);
    end
    tick();
    mem_resp_valid = 1'b0;
  endtask

  task automatic serve_line(input logic [1:0] s, input logic [15:0] d0);
    accept();
    for (int i = 0; i < 4; i++) beat(s, i, d0 + 16'(i), 1'b1);
  endtask

  // Monitor: compare every observed request handshake, fill and done pulse against the queues.
  initial begin
    logic [15:0] ea;
    fill_t       ef;
    logic [1:0]  es;
    forever begin
      @(negedge clk);
      if (!sync_rst && clk_en) begin
        if (mem_req_valid && mem_req_ready) begin
          n_vec++;
          if (exp_req.size() == 0) begin
            n_err++;
            $display("FAIL req_unexpected got=addr_%0h expected=no_request", mem_req_addr);
          end else begin
            ea = exp_req.pop_front();
            if (mem_req_addr !== ea) begin
              n_err++;
              $display("FAIL req_addr got=%0h expected=%0h", mem_req_addr, ea);
            end
          end
        end
        if (fill_we) begin
          n_vec++;
          if (exp_fill.size() == 0) begin
            n_err++;
            $display("FAIL fill_unexpected got=slot%0d_beat%0d_data%0h expected=no_fill",
                     fill_slot, fill_beat, fill_data);
          end else begin
            ef = exp_fill.pop_front();
            if (fill_slot !== ef.slot || fill_beat !== ef.beat || fill_data !== ef.data) begin
              n_err++;
              $display("FAIL fill got=slot%0d_beat%0d_data%0h expected=slot%0d_beat%0d_data%0h",
                       fill_slot, fill_beat, fill_data, ef.slot, ef.beat, ef.data);
            end
          end
        end
        if (done_valid) begin
          n_vec++;
          if (exp_done.size() == 0) begin
            n_err++;
            $display("FAIL done_unexpected got=slot%0d expected=no_done", done_slot);
          end else begin
            es = exp_done.pop_front();
            if (done_slot !== es) begin
              n_err++;
              $display("FAIL done_slot got=%0d expected=%0d", done_slot, es);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=still_running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sync_rst       = 1'b1;
    clk_en         = 1'b1;
    cmd_valid      = 1'b0;
    cmd_addr       = '0;
    cmd_slot       = '0;
    cancel         = 1'b0;
    slot_clean     = 4'hF;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    repeat (2) tick();
    chk_idle_outputs("reset");
    sync_rst = 1'b0;
    tick();

    // Single fetch with two-cycle request latency
    push_cmd(16'h1235, 2'd1, 16'h1230, 1'b1);
    chk("t1_lat_idle", mem_req_valid, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_lat_wait", mem_req_valid, 0);
    tick();
    chk("t1_lat_req", mem_req_valid, 1);
    chk("t1_req_addr", mem_req_addr, 16'h1230);
    serve_line(2'd1, 16'h00A0);
    repeat (2) tick();

    // Dirty slot holds the request; stray response beats are ignored
    slot_clean = 4'b1011;
    push_cmd(16'h2004, 2'd2, 16'h2000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = 16'hEEEE;
      chk("t2_dirty_hold", mem_req_valid, 0);
      tick();
    end
    mem_resp_valid = 1'b0;
    chk("t2_dirty_hold", mem_req_valid, 0);
    slot_clean = 4'hF;
    tick();
    chk("t2_clean_req", mem_req_valid, 1);
    slot_clean = 4'b1011;
    serve_line(2'd2, 16'h00B0);
    slot_clean = 4'hF;
    repeat (2) tick();

    // Backpressure: five accepted, sixth refused, then served in order
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_addr  = 16'h3000 + 16'(i * 8) + 16'(i);
      cmd_slot  = 2'(i % 4);
      chk("t3_cmd_ready", cmd_ready, (i < 5) ? 1 : 0);
      if (i < 5) exp_req.push_back(16'h3000 + 16'(i * 8));
      tick();
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) serve_line(2'(i % 4), 16'h00C0 + 16'(i * 16));
    repeat (2) tick();
    chk("t3_drained_busy", busy, 0);

    // Cancel mid-line with two queued commands and a same-cycle push
    push_cmd(16'h4000, 2'd0, 16'h4000, 1'b1);
    push_cmd(16'h4100, 2'd1, 16'h4100, 1'b0);
    push_cmd(16'h4200, 2'd2, 16'h4200, 1'b0);
    accept();
    beat(2'd0, 0, 16'h0040, 1'b1);
    beat(2'd0, 1, 16'h0041, 1'b1);
    cancel    = 1'b1;
    cmd_valid = 1'b1;
    cmd_addr  = 16'h4308;
    cmd_slot  = 2'd3;
    exp_req.push_back(16'h4308);
    tick();
    cancel    = 1'b0;
    cmd_valid = 1'b0;
    beat(2'd0, 2, 16'h0042, 1'b0);
    beat(2'd0, 3, 16'h0043, 1'b0);
    serve_line(2'd3, 16'h00D0);
    repeat (2) tick();
    chk("t4_busy_after", busy, 0);

    // Asynchronous reset while beats are streaming
    push_cmd(16'h5010, 2'd2, 16'h5010, 1'b1);
    accept();
    beat(2'd2, 0, 16'h0050, 1'b1);
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 16'h0051;
    #2 sync_rst = 1'b1;
    #1 chk_idle_outputs("rst_mid");
    tick();
    sync_rst = 1'b0;
    for (int k = 0; k < 3; k++) beat(2'd2, k + 1, 16'h0052 + 16'(k), 1'b0);
    chk("t5_busy_post", busy, 0);
    chk("t5_fill_post", fill_we, 0);

    // Clock enable freeze during a line
    push_cmd(16'h600F, 2'd3, 16'h6008, 1'b1);
    accept();
    beat(2'd3, 0, 16'h00F0, 1'b1);
    beat(2'd3, 1, 16'h00F1, 1'b1);
    clk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_resp_valid = (k != 1);
      mem_resp_data  = 16'hEEEE;
      chk("t6_frozen_we", fill_we, 1);
      chk("t6_frozen_beat", fill_beat, 1);
      chk("t6_frozen_data", fill_data, 16'h00F1);
      tick();
    end
    mem_resp_valid = 1'b0;
    clk_en = 1'b1;
    beat(2'd3, 2, 16'h00F2, 1'b1);
    beat(2'd3, 3, 16'h00F3, 1'b1);
    repeat (4) tick();

    chk("end_req_queue", exp_req.size(), 0);
    chk("end_fill_queue", exp_fill.size(), 0);
    chk("end_done_queue", exp_done.size(), 0);
    chk("end_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stack_cache_line_fetch_unit.md
Name: stack_cache_line_fetch_unit

Overview:
Downstream fetch engine for the stack-cache line state machine. It queues line-fetch commands (line address plus destination slot 2'b00..2'b11) and waits until the destination slot is clean before fetching. It then issues one memory read per line, streams the returned beats into the line storage, and reports completion so the state machine can mark the slot Valid. It also supports cancel, used when a new stack pointer replaces the pending fetches.

Parameters:
ADDR_WIDTH, 16, byte address width
DATA_WIDTH, 16, memory beat width in bits
LINE_BEATS, 4, beats per line (power of 2; default line = 8 bytes)
QUEUE_DEPTH, 4, command FIFO entries (power of 2)

Ports:
clk  in  1  clock
sync_rst  in  1  reset; asynchronous, active-high
clk_en  in  1  clock enable; all state frozen when low
cmd_valid  in  1  fetch command offered
cmd_ready  out  1  command FIFO not full
cmd_addr  in  ADDR_WIDTH  any byte address within the target line
cmd_slot  in  2  destination line slot
cancel  in  1  discard queued and in-flight fetches
slot_clean  in  4  per-slot clean status; bit n = slot n holds no dirty data
mem_req_valid  out  1  line read request
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_WIDTH  line-aligned read address
mem_resp_valid  in  1  response beat present
mem_resp_data  in  DATA_WIDTH  response beat, in ascending order
fill_we  out  1  write one beat into line storage
fill_slot  out  2  slot being filled
fill_beat  out  log2(LINE_BEATS)  beat index
fill_data  out  DATA_WIDTH  beat data
done_valid  out  1  one-cycle pulse: slot fill complete
done_slot  out  2  completed slot
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (async): FIFO empty, state IDLE, squash=0. All outputs 0 except cmd_ready=1.
- Transfers and state updates occur only on cycles with clk_en=1. Outputs hold when clk_en=0.
- FIFO push: cmd_valid & cmd_ready. cmd_ready = !full, with no pop-bypass when full.
- Address alignment: the low log2(LINE_BEATS*DATA_WIDTH/8) bits of cmd_addr are forced to 0 at push (3 bits by default).
- FSM states:
  - IDLE: if FIFO non-empty, pop head into cur_addr/cur_slot and go to WAIT_CLEAN.
  - WAIT_CLEAN: if slot_clean[cur_slot]=1, go to REQ; otherwise stay.
  - REQ: mem_req_valid=1 and mem_req_addr=cur_addr, both stable until accepted. On mem_req_ready, clear the beat counter and go to BEAT.
  - BEAT: each mem_resp_valid increments the beat counter. The following cycle, fill_we=1 with fill_slot=cur_slot, fill_beat=index, fill_data=beat (registered outputs). When beat LINE_BEATS-1 is accepted, go to DONE.
  - DONE: done_valid=1 and done_slot=cur_slot for one cycle (this is the cycle of the final fill_we), then go to IDLE.
- Latency from a push into an empty, idle unit with a clean slot to mem_req_valid: 2 cycles (IDLE, WAIT_CLEAN).
- Cancel:
  - The FIFO is cleared.
  - A cmd pushed in the same cycle as cancel is retained as the sole FIFO entry.
  - In WAIT_CLEAN or REQ (request not yet accepted): go to IDLE immediately. No request is issued.
  - In REQ with mem_req_ready in the same cycle: the request is accepted, then squash is set.
  - In BEAT: set squash. Remaining beats are consumed with fill_we suppressed, there is no done pulse, and the FSM returns to IDLE.
  - In DONE: the done pulse still fires (the fill is already complete).
  - Cancel while IDLE with an empty FIFO has no effect.
- mem_resp_valid outside BEAT is ignored.
- slot_clean dropping after leaving WAIT_CLEAN has no effect.
- Pointers wrap modulo QUEUE_DEPTH. The count is held in log2(QUEUE_DEPTH)+1 bits.

Test Plan:
- Single fetch: push addr 0x1235, slot 1, slot_clean=4'hF. Expected: mem_req_addr=0x1230 two cycles later. Respond with beats 0xA0,0xA1,0xA2,0xA3. Expected: fill_we beats 0..3 on slot 1 with matching data, and done_valid with done_slot=1 on the last fill cycle.
- Dirty wait: push slot 2 with slot_clean[2]=0 held for 5 cycles. Expected: mem_req_valid stays 0 during those cycles and asserts the cycle after slot_clean[2] rises.
- Backpressure/full: hold mem_req_ready=0 and offer 6 commands. Expected: 5 accepted (1 current + 4 FIFO), cmd_ready=0 at the 6th. Release ready. Expected: requests issue in push order.
- Cancel mid-line: assert cancel after beat 1 while 2 commands are queued and a new cmd for slot 3 is pushed in the same cycle. Expected: no fill_we for beats 2-3, no done pulse; the next request is for the slot 3 command only.
- Reset mid-BEAT: assert sync_rst between clock edges. Expected: all outputs 0 immediately, cmd_ready=1, busy=0. Post-reset beats produce no fill_we.
- clk_en gating: drop clk_en for 3 cycles during BEAT while mem_resp_valid pulses. Expected: the beat counter and outputs are frozen and the transfer resumes correctly.
